uart_rx_conditioner: RTL and testbench

- Pad-side front end for the UART receive path, directly upstream of the UART controller's `rx` input.
- Synchronises the asynchronous RX pad, removes glitches and drives a clean `rx_out` into the controller.
- Also reports line status (idle, break), counts rejected glitches and, as an option, measures start-bit width for autobaud.

---
 rtl/uart_rx_conditioner.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_conditioner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_conditioner.sv
// uart_rx_conditioner: RX pad synchroniser, glitch filter, idle/break line monitor.
// Define AUTOBAUD_EN to enable start-bit width measurement on baud_div/baud_valid.
module uart_rx_conditioner #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned FILT_LEN  = 3,
    parameter int unsigned IDLE_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_pad,
    output logic        rx_out,
    output logic        line_idle,
    output logic        break_det,
    output logic        break_pulse,
    output logic [7:0]  glitch_cnt,
    input  logic        glitch_clr,
    input  logic        measure_en,
    output logic [15:0] baud_div,
    output logic        baud_valid
);
    localparam int unsigned BIT_CYC    = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BREAK_CYC  = BIT_CYC * (DATA_BITS + 2);
    localparam int unsigned IDLE_CYC   = BIT_CYC * IDLE_BITS;
    localparam logic [15:0] BIT_DIV    = 16'(BIT_CYC);
    localparam logic [15:0] BREAK_LAST = 16'(BREAK_CYC - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(IDLE_CYC - 1);

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_LOW, S_BREAK} state_t;

    logic [1:0]          sync_q, sync_d;
    logic [FILT_LEN-1:0] filt_q, filt_d;
    logic                rx_out_q, rx_out_d;
    logic                dist_q, dist_d;
    logic [7:0]          glitch_cnt_q, glitch_cnt_d;
    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d, cnt_inc;
    logic                line_idle_q, line_idle_d;
    logic                break_det_q, break_det_d;
    logic                break_pulse_q, break_pulse_d;
    logic                all_one, all_zero, all_eq_out, glitch;
`ifdef AUTOBAUD_EN
    logic                meas_q, meas_d;
    logic [15:0]         baud_div_q, baud_div_d;
    logic                baud_valid_q, baud_valid_d;
`endif

    // The filter decides on the post-shift contents so pad-to-rx_out latency is 2+FILT_LEN.
    always_comb begin
        sync_d   = {sync_q[0], rx_pad};
        filt_d   = {filt_q[FILT_LEN-2:0], sync_q[1]};
        all_one  = &filt_d;
        all_zero = ~|filt_d;
        rx_out_d = rx_out_q;
        if (rx_out_q && all_zero) begin
            rx_out_d = 1'b0;
        end else if (!rx_out_q && all_one) begin
            rx_out_d = 1'b1;
        end
        all_eq_out = rx_out_q ? all_one : all_zero;

        glitch = 1'b0;
        dist_d = dist_q;
        if (rx_out_d != rx_out_q) begin
            dist_d = 1'b0;
        end else if (all_eq_out) begin
            glitch = dist_q;
            dist_d = 1'b0;
        end else begin
            dist_d = 1'b1;
        end

        glitch_cnt_d = glitch_cnt_q;
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (glitch && glitch_cnt_q != '1) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    always_comb begin
        cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        state_d       = state_q;
        cnt_d         = cnt_q;
        break_pulse_d = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (rx_out_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= IDLE_LAST) state_d = S_IDLE;
                end else begin
                    cnt_d   = 16'd1;
                    state_d = S_LOW;
                end
            end
            S_IDLE: begin
                if (rx_out_q) begin
                    cnt_d = cnt_inc;
                end else begin
                    cnt_d   = 16'd1;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (!rx_out_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= BREAK_LAST) begin
                        state_d       = S_BREAK;
                        break_pulse_d = 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_BREAK: begin
                if (rx_out_q) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
        endcase
        line_idle_d = (state_d == S_IDLE);
        break_det_d = (state_d == S_BREAK);
    end

`ifdef AUTOBAUD_EN
    // A measurement lives only inside the S_LOW visit that followed an armed idle falling edge.
    always_comb begin
        meas_d       = 1'b0;
        baud_div_d   = baud_div_q;
        baud_valid_d = 1'b0;
        case (state_q)
            S_IDLE: meas_d = !rx_out_q && measure_en;
            S_LOW: begin
                if (measure_en && meas_q) begin
                    if (rx_out_q) begin
                        if (cnt_q >= 16'd16) begin
                            baud_div_d   = cnt_q;
                            baud_valid_d = 1'b1;
                        end
                    end else begin
                        meas_d = (state_d == S_LOW);
                    end
                end
            end
            default: meas_d = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '1;
            filt_q        <= '1;
            rx_out_q      <= 1'b1;
            dist_q        <= 1'b0;
            glitch_cnt_q  <= '0;
            state_q       <= S_WAIT;
            cnt_q         <= '0;
            line_idle_q   <= 1'b0;
            break_det_q   <= 1'b0;
            break_pulse_q <= 1'b0;
`ifdef AUTOBAUD_EN
            meas_q        <= 1'b0;
            baud_div_q    <= BIT_DIV;
            baud_valid_q  <= 1'b0;
`endif
        end else begin
            sync_q        <= sync_d;
            filt_q        <= filt_d;
            rx_out_q      <= rx_out_d;
            dist_q        <= dist_d;
            glitch_cnt_q  <= glitch_cnt_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            line_idle_q   <= line_idle_d;
            break_det_q   <= break_det_d;
            break_pulse_q <= break_pulse_d;
`ifdef AUTOBAUD_EN
            meas_q        <= meas_d;
            baud_div_q    <= baud_div_d;
            baud_valid_q  <= baud_valid_d;
`endif
        end
    end

    assign rx_out      = rx_out_q;
    assign line_idle   = line_idle_q;
    assign break_det   = break_det_q;
    assign break_pulse = break_pulse_q;
    assign glitch_cnt  = glitch_cnt_q;
`ifdef AUTOBAUD_EN
    assign baud_div    = baud_div_q;
    assign baud_valid  = baud_valid_q;
`else
    // measure_en has no effect in this build.
    assign baud_div    = BIT_DIV;
    assign baud_valid  = 1'b0 & measure_en;
`endif
endmodule

// File: tb/tb_uart_rx_conditioner.sv
// tb_uart_rx_conditioner: directed and randomized pad stimulus checked every cycle against
// a run-length reference model of filtering, glitch counting, idle/break and autobaud.
`timescale 1ns/1ps
module tb_uart_rx_conditioner;
    localparam int unsigned CLK_FREQ  = 50000000;
    localparam int unsigned BIT_CYC   = CLK_FREQ / 115200;
    localparam int unsigned FILT_LEN  = 3;
    localparam int unsigned IDLE_CYC  = BIT_CYC * 10;
    localparam int unsigned BREAK_CYC = BIT_CYC * (8 + 2);
`ifdef AUTOBAUD_EN
    // A 9600-baud start bit (5208 cycles) is longer than BREAK_CYC at these parameters,
    // so the measurable frame is sent at 14400 baud.
    localparam int unsigned AB_BIT    = CLK_FREQ / 14400;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pad = 1'b1;
    logic        glitch_clr = 1'b0;
    logic        measure_en = 1'b0;
    logic        rx_out, line_idle, break_det, break_pulse, baud_valid;
    logic [7:0]  glitch_cnt;
    logic [15:0] baud_div;

    always #5 clk = ~clk;

    uart_rx_conditioner #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(115200),
        .DATA_BITS(8),
        .FILT_LEN (FILT_LEN),
        .IDLE_BITS(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_pad     (rx_pad),
        .rx_out     (rx_out),
        .line_idle  (line_idle),
        .break_det  (break_det),
        .break_pulse(break_pulse),
        .glitch_cnt (glitch_cnt),
        .glitch_clr (glitch_clr),
        .measure_en (measure_en),
        .baud_div   (baud_div),
        .baud_valid (baud_valid)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: pad sample history plus run lengths of the filtered level.
    logic        m_hist [FILT_LEN+2];
    logic        m_rx, m_dist, m_armed, m_valid;
    int unsigned m_hi, m_lo, m_gcnt, m_div;

    task automatic model_reset();
        for (int i = 0; i < FILT_LEN + 2; i++) m_hist[i] = 1'b1;
        m_rx = 1'b1; m_dist = 1'b0; m_armed = 1'b0; m_valid = 1'b0;
        m_hi = 1; m_lo = 0; m_gcnt = 0; m_div = BIT_CYC;
    endtask

    task automatic model_edge();
        logic        prev_rx, win_same, win_eq, changed, glitch;
        logic        was_idle, was_low;
        int unsigned prev_lo;
        prev_rx  = m_rx;
        prev_lo  = m_lo;
        was_idle = (m_hi >= IDLE_CYC);
        was_low  = (prev_lo >= 1) && (prev_lo < BREAK_CYC - 1);
        for (int i = FILT_LEN + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = rx_pad;
        win_same = 1'b1;
        win_eq   = 1'b1;
        for (int i = 2; i < FILT_LEN + 2; i++) begin
            if (m_hist[i] != m_hist[2]) win_same = 1'b0;
            if (m_hist[i] != prev_rx) win_eq = 1'b0;
        end
        changed = win_same && (m_hist[2] != prev_rx);
        if (changed) m_rx = m_hist[2];
        glitch = 1'b0;
        if (changed) m_dist = 1'b0;
        else if (win_eq) begin glitch = m_dist; m_dist = 1'b0; end
        else m_dist = 1'b1;
        if (glitch_clr) m_gcnt = 0;
        else if (glitch && m_gcnt < 255) m_gcnt++;
        if (prev_rx) begin m_hi++; m_lo = 0; end
        else begin m_lo++; m_hi = 0; end
        m_valid = 1'b0;
`ifdef AUTOBAUD_EN
        if (was_idle) m_armed = !prev_rx && measure_en;
        else if (was_low) begin
            if (!measure_en) m_armed = 1'b0;
            else if (prev_rx) begin
                if (m_armed && prev_lo >= 16) begin m_div = prev_lo; m_valid = 1'b1; end
                m_armed = 1'b0;
            end else if (m_lo >= BREAK_CYC - 1) m_armed = 1'b0;
        end else m_armed = 1'b0;
`else
        if (was_idle && was_low) m_armed = 1'b0;
`endif
    endtask

    task automatic compare_all();
        check("rx_out",      32'(rx_out),      32'(m_rx));
        check("line_idle",   32'(line_idle),   32'(m_hi >= IDLE_CYC));
        check("break_det",   32'(break_det),   32'(m_lo >= BREAK_CYC - 1));
        check("break_pulse", 32'(break_pulse), 32'(m_lo == BREAK_CYC - 1));
        check("glitch_cnt",  32'(glitch_cnt),  m_gcnt);
        check("baud_div",    32'(baud_div),    m_div);
        check("baud_valid",  32'(baud_valid),  32'(m_valid));
    endtask

    // Event log taken from DUT outputs, used for directed latency checks.
    int unsigned cyc = 0;
    int unsigned fall_at, rise_at, idle_rise_at, idle_fall_at, brk_fall_at, pulse_at;
    int unsigned n_fall, n_pulse, n_valid, n_valid_total = 0;
    logic        last_rx = 1'b1, last_idle = 1'b0, last_brk = 1'b0;

    task automatic clear_events();
        fall_at = 0; rise_at = 0; idle_rise_at = 0; idle_fall_at = 0;
        brk_fall_at = 0; pulse_at = 0; n_fall = 0; n_pulse = 0; n_valid = 0;
    endtask

    task automatic track();
        if (last_rx && !rx_out) begin fall_at = cyc; n_fall++; end
        if (!last_rx && rx_out) rise_at = cyc;
        if (!last_idle && line_idle) idle_rise_at = cyc;
        if (last_idle && !line_idle) idle_fall_at = cyc;
        if (last_brk && !break_det) brk_fall_at = cyc;
        if (break_pulse) begin n_pulse++; pulse_at = cyc; end
        if (baud_valid) begin n_valid++; n_valid_total++; end
        last_rx = rx_out; last_idle = line_idle; last_brk = break_det;
    endtask

    task automatic step(input logic pad);
        rx_pad = pad;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        cyc++;
        @(negedge clk);
        compare_all();
        track();
    endtask

    task automatic hold(input logic pad, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(pad);
    endtask

    task automatic pulse_low2(input int unsigned high_after);
        step(1'b0);
        step(1'b0);
        hold(1'b1, high_after);
    endtask

    int unsigned t0, len;
    logic        level;
`ifdef AUTOBAUD_EN
    logic [9:0]  frame;
`endif

    initial begin
        clear_events();
        hold(1'b1, 3);
        rst = 1'b0;
        t0 = cyc;
        hold(1'b1, IDLE_CYC + 10);
        check("idle_from_reset", idle_rise_at - t0, IDLE_CYC - 1);
        check("reset_no_fall", n_fall, 0);

`ifdef AUTOBAUD_EN
        measure_en = 1'b1;
        clear_events();
        frame = {1'b1, 8'h55, 1'b0};
        for (int unsigned b = 0; b < 10; b++) hold(frame[b], AB_BIT);
        measure_en = 1'b0;
        check("ab_pulses", n_valid, 1);
        check("ab_div", 32'(baud_div), AB_BIT);
        hold(1'b1, IDLE_CYC);
`endif

        clear_events();
        pulse_low2(8);
        check("glitch_one", 32'(glitch_cnt), 1);
        check("glitch_rx_stable", n_fall, 0);
        check("glitch_idle_kept", 32'(line_idle), 1);
        for (int unsigned i = 0; i < 300; i++) pulse_low2(6);
        check("glitch_saturate", 32'(glitch_cnt), 255);
        glitch_clr = 1'b1; step(1'b1); glitch_clr = 1'b0;
        check("glitch_clear", 32'(glitch_cnt), 0);
        pulse_low2(4);
        glitch_clr = 1'b1; step(1'b1); glitch_clr = 1'b0;
        check("clear_beats_incr", 32'(glitch_cnt), 0);
        hold(1'b1, 4);

        measure_en = 1'b1;
        clear_events();
        hold(1'b0, 10);
        hold(1'b1, IDLE_CYC + 60);
        check("short_low_no_update", n_valid, 0);
        check("short_low_idle_back", 32'(line_idle), 1);

        clear_events();
        t0 = cyc;
        hold(1'b0, BIT_CYC);
        hold(1'b1, IDLE_CYC + 20);
        check("fall_latency", fall_at - t0, 2 + FILT_LEN);
        check("low_width", rise_at - fall_at, BIT_CYC);
        check("idle_dropped", 32'(idle_fall_at != 0), 1);
        check("idle_return", idle_rise_at - rise_at, IDLE_CYC);
        check("bit_no_break", n_pulse, 0);
        check("bit_div", 32'(baud_div), BIT_CYC);

        clear_events();
        hold(1'b0, 5000);
        check("break_held", 32'(break_det), 1);
        hold(1'b1, 20);
        measure_en = 1'b0;
        check("break_pulse_once", n_pulse, 1);
        check("break_pulse_delay", pulse_at - fall_at, BREAK_CYC - 1);
        check("break_release", brk_fall_at - rise_at, 1);
        check("break_then_wait", 32'({break_det, line_idle}), 0);
        check("break_no_measure", n_valid, 0);

        glitch_clr = 1'b1; step(1'b1); glitch_clr = 1'b0;
        for (int unsigned i = 0; i < 7; i++) pulse_low2(6);
        check("glitch_seven", 32'(glitch_cnt), 7);
        hold(1'b0, 4400);
        check("break_before_rst", 32'(break_det), 1);
        rst = 1'b1; step(1'b0); rst = 1'b0;
        check("rst_break_det", 32'(break_det), 0);
        check("rst_glitch_cnt", 32'(glitch_cnt), 0);
        check("rst_line_idle", 32'(line_idle), 0);
        check("rst_rx_out", 32'(rx_out), 1);
        clear_events();
        hold(1'b0, 4400);
        check("break_at_reset_exit", n_pulse, 1);
        hold(1'b1, 20);

        level = 1'b1;
        for (int unsigned r = 0; r < 200; r++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 6);
            if ($urandom_range(0, 3) != 0) level = ~level;
            measure_en = 1'($urandom_range(0, 1));
            glitch_clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            step(level);
            glitch_clr = 1'b0;
            rst = 1'b0;
            hold(level, len - 1);
        end

`ifndef AUTOBAUD_EN
        check("baud_valid_never", n_valid_total, 0);
        check("baud_div_nominal", 32'(baud_div), BIT_CYC);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
